rtcl_p3s7_led_sequencer: RTL and testbench

RTCL_P3S7_LED_SEQUENCER -- requirements
Module: rtcl_p3s7_led_sequencer

---
 rtl/rtcl_p3s7_led_sequencer.sv | 177 +++++++++++++++++
 tb/tb_rtcl_p3s7_led_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtcl_p3s7_led_sequencer.sv
// Shared status LED: fixed-priority owner arbitration once per tick, with
// off/on/blink drive and a locked pulse-count burst followed by a quiet gap.
module rtcl_p3s7_led_sequencer #(
  parameter int N_REQ       = 4,
  parameter int TICK_DIV    = 50_000,
  parameter int BLINK_TICKS = 250,
  parameter int PULSE_TICKS = 100,
  parameter int GAP_TICKS   = 500
) (
  input  logic                 clk50,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [2*N_REQ-1:0]   req_mode,
  input  logic [4*N_REQ-1:0]   req_count,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 led
);

  localparam int PS_W   = $clog2(TICK_DIV);
  localparam int BL_W   = $clog2(BLINK_TICKS + 1);
  localparam int PH_MAX = (BLINK_TICKS > PULSE_TICKS) ?
                          ((BLINK_TICKS > GAP_TICKS) ? BLINK_TICKS : GAP_TICKS) :
                          ((PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;
  localparam logic [1:0] M_COUNT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_PULSE_ON, S_PULSE_OFF, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [PS_W-1:0]   r_presc;
  logic [BL_W-1:0]   r_blink_cnt;
  logic              r_blink_phase;
  logic [PH_W-1:0]   r_phase, w_phase_nxt;
  logic [3:0]        r_pulse, w_pulse_nxt, w_pulse_dec;
  logic [1:0]        r_mode, w_mode_nxt;
  logic [N_REQ-1:0]  w_grant_nxt, w_win_1h;
  logic              w_busy_nxt, w_led_nxt;
  logic              w_tick, w_blink_wrap, w_ph_pulse_end, w_ph_gap_end;
  logic              w_win_vld;
  logic [1:0]        w_win_mode;
  logic [3:0]        w_win_cnt;

  function automatic logic mode_led(input logic [1:0] mode, input logic phase);
    case (mode)
      M_ON:    return 1'b1;
      M_BLINK: return phase;
      default: return 1'b0;
    endcase
  endfunction

  assign w_tick         = (r_presc == PS_W'(TICK_DIV - 1));
  assign w_blink_wrap   = (r_blink_cnt == BL_W'(BLINK_TICKS - 1));
  assign w_ph_pulse_end = (r_phase == PH_W'(PULSE_TICKS - 1));
  assign w_ph_gap_end   = (r_phase == PH_W'(GAP_TICKS - 1));
  assign w_pulse_dec    = r_pulse - 4'd1;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_presc       <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
      if (w_tick) begin
        r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BL_W'(1);
        if (w_blink_wrap) r_blink_phase <= ~r_blink_phase;
      end
    end
  end

  // Descending scan so the lowest valid index is the last to assign.
  always_comb begin
    w_win_vld  = 1'b0;
    w_win_1h   = '0;
    w_win_mode = 2'b00;
    w_win_cnt  = 4'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_win_vld     = 1'b1;
        w_win_1h      = '0;
        w_win_1h[i]   = 1'b1;
        w_win_mode    = req_mode[2*i +: 2];
        w_win_cnt     = req_count[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      case (r_state)
        S_IDLE:      if (w_win_vld && w_win_mode == M_COUNT) w_state_nxt = S_PULSE_ON;
        S_PULSE_ON:  if (w_ph_pulse_end) w_state_nxt = S_PULSE_OFF;
        S_PULSE_OFF: if (w_ph_pulse_end) w_state_nxt = (w_pulse_dec != 4'd0) ? S_PULSE_ON : S_GAP;
        S_GAP:       if (w_ph_gap_end) w_state_nxt = S_IDLE;
        default:     w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_led_nxt   = led;
    w_busy_nxt  = busy;
    w_grant_nxt = grant;
    w_phase_nxt = r_phase;
    w_pulse_nxt = r_pulse;
    w_mode_nxt  = r_mode;
    case (r_state)
      S_IDLE: begin
        w_led_nxt = mode_led(r_mode, r_blink_phase);
        if (w_tick) begin
          w_grant_nxt = w_win_1h;
          w_mode_nxt  = w_win_mode;
          w_led_nxt   = mode_led(w_win_mode, r_blink_phase);
          if (w_win_vld && w_win_mode == M_COUNT) begin
            w_pulse_nxt = (w_win_cnt == 4'd0) ? 4'd1 : w_win_cnt;
            w_phase_nxt = '0;
            w_busy_nxt  = 1'b1;
            w_led_nxt   = 1'b1;
          end
        end
      end
      S_PULSE_ON: begin
        w_led_nxt = 1'b1;
        if (w_tick) begin
          w_phase_nxt = w_ph_pulse_end ? '0 : r_phase + PH_W'(1);
          if (w_ph_pulse_end) w_led_nxt = 1'b0;
        end
      end
      S_PULSE_OFF: begin
        w_led_nxt = 1'b0;
        if (w_tick) begin
          w_phase_nxt = w_ph_pulse_end ? '0 : r_phase + PH_W'(1);
          if (w_ph_pulse_end) begin
            w_pulse_nxt = w_pulse_dec;
            w_led_nxt   = (w_pulse_dec != 4'd0);
          end
        end
      end
      default: begin
        w_led_nxt = 1'b0;
        if (w_tick) begin
          w_phase_nxt = w_ph_gap_end ? '0 : r_phase + PH_W'(1);
          if (w_ph_gap_end) w_busy_nxt = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      led     <= 1'b0;
      busy    <= 1'b0;
      grant   <= '0;
      r_phase <= '0;
      r_pulse <= 4'd0;
      r_mode  <= 2'b00;
    end else begin
      led     <= w_led_nxt;
      busy    <= w_busy_nxt;
      grant   <= w_grant_nxt;
      r_phase <= w_phase_nxt;
      r_pulse <= w_pulse_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

endmodule

// File: tb/tb_rtcl_p3s7_led_sequencer.sv
// Bench for the LED sequencer: per-tick reference model with a burst queue,
// directed scenarios plus randomized requester traffic.
module tb_rtcl_p3s7_led_sequencer;
  localparam int N_REQ       = 4;
  localparam int TICK_DIV    = 4;
  localparam int BLINK_TICKS = 3;
  localparam int PULSE_TICKS = 2;
  localparam int GAP_TICKS   = 5;

  logic         clk50 = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [7:0]   req_mode  = '0;
  logic [15:0]  req_count = '0;
  logic [3:0]   grant;
  logic         busy, led;

  int n_vec = 0;
  int n_err = 0;

  int         m_edge, m_ticks;
  logic [3:0] m_grant;
  logic [1:0] m_mode;
  logic       m_busy, m_led, m_inburst;
  bit         m_q[$];

  rtcl_p3s7_led_sequencer #(
    .N_REQ(N_REQ), .TICK_DIV(TICK_DIV), .BLINK_TICKS(BLINK_TICKS),
    .PULSE_TICKS(PULSE_TICKS), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk50(clk50), .reset(reset), .req_valid(req_valid), .req_mode(req_mode),
    .req_count(req_count), .grant(grant), .busy(busy), .led(led)
  );

  always #5 clk50 = ~clk50;

  function automatic logic mdec(input logic [1:0] m, input logic ph);
    if (m == 2'b01) return 1'b1;
    if (m == 2'b10) return ph;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_edge = 0; m_ticks = 0; m_grant = '0; m_mode = '0;
    m_busy = 1'b0; m_led = 1'b0; m_inburst = 1'b0;
    m_q.delete();
  endtask

  task automatic set_req(input int idx, input logic v, input logic [1:0] md, input logic [3:0] cn);
    req_valid[idx]        = v;
    req_mode[2*idx +: 2]  = md;
    req_count[4*idx +: 4] = cn;
  endtask

  // One clock: the model sees inputs as they stand at the edge.
  task automatic cyc();
    logic [3:0]  v;
    logic [7:0]  md;
    logic [15:0] cn;
    logic [3:0]  k;
    logic        ph;
    int          n;
    v = req_valid; md = req_mode; cn = req_count; k = '0;
    @(posedge clk50);
    m_edge++;
    ph = ((m_ticks / BLINK_TICKS) % 2) == 1;
    if (m_edge % TICK_DIV == 0) begin
      m_ticks++;
      if (m_inburst) begin
        if (m_q.size() == 0) begin
          m_inburst = 1'b0; m_busy = 1'b0; m_led = 1'b0;
        end else m_led = m_q.pop_front();
      end else begin
        m_grant = '0; m_mode = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
          if (v[i]) begin
            m_grant = 4'(1 << i); m_mode = md[2*i +: 2]; k = cn[4*i +: 4];
          end
        if (m_grant != 0 && m_mode == 2'b11) begin
          n = (k == 0) ? 1 : int'(k);
          for (int p = 0; p < n; p++) begin
            repeat (PULSE_TICKS) m_q.push_back(1'b1);
            repeat (PULSE_TICKS) m_q.push_back(1'b0);
          end
          repeat (GAP_TICKS) m_q.push_back(1'b0);
          m_inburst = 1'b1; m_busy = 1'b1; m_led = m_q.pop_front();
        end else m_led = mdec(m_mode, ph);
      end
    end else if (!m_inburst) m_led = mdec(m_mode, ph);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk50);
    #1;
    n_vec++;
    if ({grant, busy, led} !== 6'b0) begin
      n_err++; $display("FAIL reset_state got grant=%b busy=%b led=%b want 0000 0 0", grant, busy, led);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_steady_on();
    set_req(0, 1'b1, 2'b01, 4'd0);
    for (int c = 0; c < 12; c++) begin
      cyc(); n_vec++;
      if ({grant, busy, led} !== {m_grant, m_busy, m_led}) begin
        n_err++; $display("FAIL steady_on cyc%0d got %b_%b_%b want %b_%b_%b", c, grant, busy, led, m_grant, m_busy, m_led);
      end
    end
    n_vec++;
    if (grant !== 4'b0001 || led !== 1'b1) begin
      n_err++; $display("FAIL steady_on_final got grant=%b led=%b want 0001 1", grant, led);
    end
    req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      cyc(); n_vec++;
      if ({grant, busy, led} !== {m_grant, m_busy, m_led}) begin
        n_err++; $display("FAIL steady_off cyc%0d got %b_%b_%b want %b_%b_%b", c, grant, busy, led, m_grant, m_busy, m_led);
      end
    end
    n_vec++;
    if (grant !== 4'b0000 || led !== 1'b0) begin
      n_err++; $display("FAIL steady_off_final got grant=%b led=%b want 0000 0", grant, led);
    end
  endtask

  task automatic test_priority();
    int toggles;
    logic prev;
    set_req(1, 1'b1, 2'b10, 4'd0);
    set_req(3, 1'b1, 2'b01, 4'd0);
    toggles = 0;
    prev = led;
    for (int c = 0; c < 40; c++) begin
      cyc(); n_vec++;
      if ({grant, busy, led} !== {m_grant, m_busy, m_led}) begin
        n_err++; $display("FAIL priority cyc%0d got %b_%b_%b want %b_%b_%b", c, grant, busy, led, m_grant, m_busy, m_led);
      end
      if (c >= 4 && led !== prev) toggles++;
      prev = led;
    end
    n_vec++;
    if (toggles < 2) begin
      n_err++; $display("FAIL priority_blink got toggles=%0d want >=2", toggles);
    end
    req_valid = 4'b1000;
    for (int c = 0; c < 4; c++) cyc();
    n_vec++;
    if (grant !== 4'b1000 || led !== 1'b1) begin
      n_err++; $display("FAIL priority_switch got grant=%b led=%b want 1000 1", grant, led);
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) cyc();
  endtask

  task automatic test_count_burst();
    int nbusy;
    req_valid = '0;
    set_req(2, 1'b1, 2'b11, 4'd3);
    nbusy = 0;
    for (int c = 0; c < 8 && nbusy == 0; c++) begin
      cyc();
      if (busy === 1'b1) nbusy = 1;
    end
    n_vec++;
    if (nbusy != 1) begin
      n_err++; $display("FAIL burst_start got busy=%b want 1 within 8 cycles", busy);
    end
    for (int c = 0; c < 70; c++) begin
      cyc(); n_vec++;
      if ({grant, busy, led} !== {m_grant, m_busy, m_led}) begin
        n_err++; $display("FAIL burst cyc%0d got %b_%b_%b want %b_%b_%b", c, grant, busy, led, m_grant, m_busy, m_led);
      end
      if (busy === 1'b1) nbusy++;
      if (grant !== 4'b0100) begin
        n_err++; $display("FAIL burst_grant cyc%0d got %b want 0100", c, grant);
      end
    end
    n_vec++;
    if (nbusy != 17 * TICK_DIV) begin
      n_err++; $display("FAIL burst_busy_len got %0d cycles want %0d", nbusy, 17 * TICK_DIV);
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) cyc();
  endtask

  task automatic test_lock_count0();
    int n, nbusy;
    bit started;
    n = $urandom_range(1, 4);
    req_valid = '0;
    set_req(2, 1'b1, 2'b11, 4'(n));
    started = 0;
    for (int c = 0; c < 8 && !started; c++) begin cyc(); started = (busy === 1'b1); end
    for (int c = 0; c < (4*n + 5) * TICK_DIV + 8; c++) begin
      if (c == 6) begin
        req_valid = 4'b0001;
        req_mode  = 8'($urandom) | 8'b0000_0001;
        req_mode[1:0] = 2'b01;
        req_count = 16'($urandom);
      end
      cyc(); n_vec++;
      if ({grant, busy, led} !== {m_grant, m_busy, m_led}) begin
        n_err++; $display("FAIL lock n=%0d cyc%0d got %b_%b_%b want %b_%b_%b", n, c, grant, busy, led, m_grant, m_busy, m_led);
      end
    end
    n_vec++;
    if (grant !== 4'b0001 || busy !== 1'b0 || led !== 1'b1) begin
      n_err++; $display("FAIL lock_after got grant=%b busy=%b led=%b want 0001 0 1", grant, busy, led);
    end
    req_valid = '0;
    req_mode  = '0;
    req_count = '0;
    set_req(0, 1'b1, 2'b11, 4'd0);
    nbusy = 0;
    for (int c = 0; c < 8 && nbusy == 0; c++) begin
      cyc();
      if (busy === 1'b1) nbusy = 1;
    end
    req_valid = '0;
    for (int c = 0; c < 40; c++) begin
      cyc(); n_vec++;
      if ({grant, busy, led} !== {m_grant, m_busy, m_led}) begin
        n_err++; $display("FAIL count0 cyc%0d got %b_%b_%b want %b_%b_%b", c, grant, busy, led, m_grant, m_busy, m_led);
      end
      if (busy === 1'b1) nbusy++;
    end
    n_vec++;
    if (nbusy != (2*PULSE_TICKS + GAP_TICKS) * TICK_DIV) begin
      n_err++; $display("FAIL count0_len got %0d busy cycles want %0d", nbusy, (2*PULSE_TICKS + GAP_TICKS) * TICK_DIV);
    end
  endtask

  task automatic test_reset_mid();
    bit started;
    req_valid = '0;
    set_req(2, 1'b1, 2'b11, 4'd5);
    started = 0;
    for (int c = 0; c < 8 && !started; c++) begin cyc(); started = (busy === 1'b1); end
    cyc(); cyc();
    #3 reset = 1'b1;
    #1;
    n_vec++;
    if ({grant, busy, led} !== 6'b0) begin
      n_err++; $display("FAIL reset_mid got grant=%b busy=%b led=%b want 0000 0 0", grant, busy, led);
    end
    repeat (2) @(posedge clk50);
    #1;
    req_valid = '0;
    set_req(0, 1'b1, 2'b01, 4'd0);
    reset = 1'b0;
    model_reset();
    for (int c = 1; c <= 4; c++) begin
      cyc(); n_vec++;
      if ({grant, busy, led} !== {m_grant, m_busy, m_led}) begin
        n_err++; $display("FAIL reset_release cyc%0d got %b_%b_%b want %b_%b_%b", c, grant, busy, led, m_grant, m_busy, m_led);
      end
      if (c == 3 && grant !== 4'b0000) begin
        n_err++; $display("FAIL release_early got grant=%b want 0000", grant);
      end
    end
    n_vec++;
    if (grant !== 4'b0001) begin
      n_err++; $display("FAIL release_arb got grant=%b want 0001", grant);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        req_valid = 4'($urandom);
        req_mode  = 8'($urandom);
        req_count = 16'($urandom) & 16'h3333;
      end
      cyc(); n_vec++;
      if ({grant, busy, led} !== {m_grant, m_busy, m_led}) begin
        n_err++; $display("FAIL random cyc%0d got %b_%b_%b want %b_%b_%b", c, grant, busy, led, m_grant, m_busy, m_led);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_steady_on();
    test_priority();
    test_count_burst();
    test_lock_count0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
